// File: rtl/cpu_interrupt_handler_if.sv
// Memory bus between the interrupt sequencer and system memory.
//   mem_addr     : bus address (driven by master)
//   mem_data_out : write data (driven by master)
//   mem_write_en : write strobe (driven by master)
//   mem_data_in  : read data, one registered stage behind mem_addr (driven by slave)
interface cpu_interrupt_handler_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        mem_write_en;

  modport master (
    output mem_addr,
    output mem_data_out,
    output mem_write_en,
    input  mem_data_in
  );

  modport slave (
    input  mem_addr,
    input  mem_data_out,
    input  mem_write_en,
    output mem_data_in
  );
endinterface

// File: rtl/cpu_interrupt_handler.sv
// Instruction-boundary interrupt sequencer for the NES 6502 core.
// Started once per instruction; either passes PC/P/SP through or owns the
// memory bus to run a soft-reset, RTI, or BRK/NMI/IRQ push-and-vector sequence.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (master)        : memory address/data/write strobe
//   start, done, busy   : per-instruction handshake
//   pc/status/stack_in  : architectural state at the boundary
//   pc/status/stack_out : resulting state, valid while done is high
//   is_break, is_rti    : current instruction decode
//   soft_reset, nIRQ    : reset request, active-low level IRQ
//   ppu_status, ppu_ctrl1 : vblank (bit 7) and NMI enable (bit 7)
//   halt                : DMA freeze
//   interrupt_disable   : status_in[2], combinational
module cpu_interrupt_handler #(
  parameter logic [15:0] NMI_VEC   = 16'hFFFA,
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
  input  logic                    clk,
  input  logic                    rst,
  cpu_interrupt_handler_if.master bus,
  input  logic                    is_break,
  input  logic [7:0]              ppu_status,
  input  logic                    soft_reset,
  input  logic                    is_rti,
  input  logic                    start,
  output logic                    done,
  output logic                    busy,
  input  logic [15:0]             pc_in,
  input  logic [7:0]              status_in,
  input  logic [7:0]              stack_in,
  output logic [15:0]             pc_out,
  output logic [7:0]              status_out,
  output logic [7:0]              stack_out,
  output logic                    interrupt_disable,
  input  logic                    halt,
  input  logic                    nIRQ,
  input  logic [7:0]              ppu_ctrl1
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] STACK_PAGE = 8'h01;

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI,
    S_CAP_LO, S_CAP_HI, S_RTI_HOLD, S_RTI_A2, S_RTI_A3
  } state_t;

  typedef enum logic [2:0] {
    SEL_PASS, SEL_RESET, SEL_RTI, SEL_BRK, SEL_NMI, SEL_IRQ
  } sel_t;

  state_t        state;
  sel_t          sel;
  logic          nmi_q, nmi_pending, rst_pending, is_rti_q;
  logic          nmi_line, nmi_edge;
  logic [DW-1:0] ptr_q, p_push_q, res_status_q, res_stack_q, lo_q, p_q;
  logic [DW-1:0] p_push;
  logic [AW-1:0] pc_push_q, vec_q, pc_push;
  logic          unused_bits;

  function automatic logic [AW-1:0] stack_addr(input logic [DW-1:0] sp);
    return {STACK_PAGE, sp};
  endfunction

  assign interrupt_disable = status_in[2];
  assign nmi_line          = ppu_status[7] & ppu_ctrl1[7];
  assign nmi_edge          = nmi_line & ~nmi_q;
  assign unused_bits       = &{1'b0, ppu_status[6:0], ppu_ctrl1[6:0]};

  // Priority selection of the sequence to run at this boundary
  always_comb begin
    sel = SEL_PASS;
    if (rst_pending)                   sel = SEL_RESET;
    else if (is_rti)                   sel = SEL_RTI;
    else if (is_break)                 sel = SEL_BRK;
    else if (nmi_pending)              sel = SEL_NMI;
    else if (!nIRQ && !status_in[2])   sel = SEL_IRQ;
  end

  // BRK pushes the address past its signature byte and sets B; NMI/IRQ clear B
  assign pc_push = (sel == SEL_BRK) ? pc_in + 16'd1 : pc_in;
  assign p_push  = (sel == SEL_BRK) ? (status_in | 8'h30)
                                    : ((status_in | 8'h20) & 8'hEF);

  // Sequencer, pending-request flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      done             <= 1'b0;
      busy             <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_data_out <= '0;
      bus.mem_write_en <= 1'b0;
      pc_out           <= '0;
      status_out       <= '0;
      stack_out        <= 8'hFF;
      nmi_q            <= 1'b0;
      nmi_pending      <= 1'b0;
      rst_pending      <= 1'b0;
      is_rti_q         <= 1'b0;
      ptr_q            <= '0;
      pc_push_q        <= '0;
      p_push_q         <= '0;
      vec_q            <= '0;
      res_status_q     <= '0;
      res_stack_q      <= '0;
      lo_q             <= '0;
      p_q              <= '0;
    end else begin
      // Edge detection keeps running through halt so a vblank is never lost
      nmi_q <= nmi_line;
      if (nmi_edge)
        nmi_pending <= 1'b1;
      else if (!halt && state == S_IDLE && start && sel == SEL_NMI)
        nmi_pending <= 1'b0;

      if (halt) begin
        bus.mem_write_en <= 1'b0;
      end else begin
        if (soft_reset)
          rst_pending <= 1'b1;
        else if (state == S_IDLE && start && sel == SEL_RESET)
          rst_pending <= 1'b0;

        bus.mem_write_en <= 1'b0;
        case (state)
          S_IDLE: begin
            if (start) begin
              case (sel)
                SEL_PASS: begin
                  pc_out     <= pc_in;
                  status_out <= status_in;
                  stack_out  <= stack_in;
                  done       <= 1'b1;
                end
                SEL_RESET: begin
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  bus.mem_addr <= RESET_VEC;
                  vec_q        <= RESET_VEC;
                  is_rti_q     <= 1'b0;
                  res_status_q <= status_in | 8'h04;
                  res_stack_q  <= stack_in - 8'd3;
                  state        <= S_VEC_HI;
                end
                SEL_RTI: begin
                  done         <= 1'b0;
                  busy         <= 1'b1;
                  bus.mem_addr <= stack_addr(stack_in + 8'd1);
                  ptr_q        <= stack_in + 8'd2;
                  is_rti_q     <= 1'b1;
                  res_stack_q  <= stack_in + 8'd3;
                  state        <= S_RTI_HOLD;
                end
                default: begin
                  done             <= 1'b0;
                  busy             <= 1'b1;
                  bus.mem_addr     <= stack_addr(stack_in);
                  bus.mem_data_out <= pc_push[15:8];
                  bus.mem_write_en <= 1'b1;
                  ptr_q            <= stack_in - 8'd1;
                  pc_push_q        <= pc_push;
                  p_push_q         <= p_push;
                  vec_q            <= (sel == SEL_NMI) ? NMI_VEC : IRQ_VEC;
                  is_rti_q         <= 1'b0;
                  res_status_q     <= (status_in & 8'hCF) | 8'h04;
                  res_stack_q      <= stack_in - 8'd3;
                  state            <= S_PUSH_PCL;
                end
              endcase
            end
          end
          S_PUSH_PCL: begin
            bus.mem_addr     <= stack_addr(ptr_q);
            bus.mem_data_out <= pc_push_q[7:0];
            bus.mem_write_en <= 1'b1;
            ptr_q            <= ptr_q - 8'd1;
            state            <= S_PUSH_P;
          end
          S_PUSH_P: begin
            bus.mem_addr     <= stack_addr(ptr_q);
            bus.mem_data_out <= p_push_q;
            bus.mem_write_en <= 1'b1;
            state            <= S_VEC_LO;
          end
          S_VEC_LO: begin
            bus.mem_addr <= vec_q;
            state        <= S_VEC_HI;
          end
          S_VEC_HI: begin
            bus.mem_addr <= vec_q + 16'd1;
            state        <= S_CAP_LO;
          end
          // First pull address is held a second cycle so P lands two edges later
          S_RTI_HOLD: state <= S_RTI_A2;
          S_RTI_A2: begin
            bus.mem_addr <= stack_addr(ptr_q);
            ptr_q        <= ptr_q + 8'd1;
            state        <= S_RTI_A3;
          end
          S_RTI_A3: begin
            bus.mem_addr <= stack_addr(ptr_q);
            p_q          <= bus.mem_data_in;
            state        <= S_CAP_LO;
          end
          S_CAP_LO: begin
            lo_q  <= bus.mem_data_in;
            state <= S_CAP_HI;
          end
          S_CAP_HI: begin
            pc_out     <= {bus.mem_data_in, lo_q};
            status_out <= is_rti_q ? (p_q & 8'hCF) : res_status_q;
            stack_out  <= res_stack_q;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_interrupt_handler.sv
// Bench for cpu_interrupt_handler: directed cases followed by randomized
// boundaries, each checked against a behavioural model of the sequences.
module tb_cpu_interrupt_handler;

  localparam int K_PASS = 0, K_RST = 1, K_RTI = 2, K_BRK = 3, K_NMI = 4, K_IRQ = 5;

  logic        clk = 1'b0;
  logic        rst, is_break, soft_reset, is_rti, start, halt, nIRQ;
  logic [7:0]  ppu_status, ppu_ctrl1, status_in, stack_in;
  logic [15:0] pc_in;
  logic        done, busy, interrupt_disable;
  logic [15:0] pc_out;
  logic [7:0]  status_out, stack_out;

  cpu_interrupt_handler_if bus ();

  cpu_interrupt_handler dut (
    .clk(clk), .rst(rst), .bus(bus),
    .is_break(is_break), .ppu_status(ppu_status), .soft_reset(soft_reset),
    .is_rti(is_rti), .start(start), .done(done), .busy(busy),
    .pc_in(pc_in), .status_in(status_in), .stack_in(stack_in),
    .pc_out(pc_out), .status_out(status_out), .stack_out(stack_out),
    .interrupt_disable(interrupt_disable), .halt(halt), .nIRQ(nIRQ),
    .ppu_ctrl1(ppu_ctrl1)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for the address registered at edge N is
  // returned at edge N+1 and sampled by the DUT at N+2.
  logic [7:0]  mem [0:65535];
  logic [7:0]  rd_q;
  logic [15:0] wl_addr [0:255];
  logic [7:0]  wl_data [0:255];
  int unsigned wr_total = 0;

  always @(posedge clk) rd_q <= mem[bus.mem_addr];
  assign bus.mem_data_in = rd_q;

  always @(posedge clk)
    if (bus.mem_write_en === 1'b1) begin
      wl_addr[wr_total[7:0]] <= bus.mem_addr;
      wl_data[wr_total[7:0]] <= bus.mem_data_out;
      wr_total <= wr_total + 1;
    end

  int vectors = 0;
  int miscompares = 0;
  bit m_prev, m_nmi, m_rst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; the model sees the same inputs the DUT samples at this edge.
  task automatic tick(input bit clr_nmi, input bit clr_rst);
    bit line;
    line = ppu_status[7] & ppu_ctrl1[7];
    if (rst) begin
      m_prev = 0; m_nmi = 0; m_rst = 0;
    end else begin
      if (line && !m_prev) m_nmi = 1;
      else if (clr_nmi)    m_nmi = 0;
      if (!halt) begin
        if (soft_reset)    m_rst = 1;
        else if (clr_rst)  m_rst = 0;
      end
      m_prev = line;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int pick();
    if (m_rst)                          return K_RST;
    if (is_rti)                         return K_RTI;
    if (is_break)                       return K_BRK;
    if (m_nmi)                          return K_NMI;
    if (!nIRQ && !status_in[2])         return K_IRQ;
    return K_PASS;
  endfunction

  task automatic run(input string tag, input logic [15:0] pc, input logic [7:0] st,
                     input logic [7:0] sp, input logic brk, input logic rti,
                     input logic nirq, input int halt_at, input int halt_len_in,
                     input bit vbl_pulse);
    int k, lat, c, halt_len;
    bit push, bad_busy, bad_we;
    logic [15:0] pcp, vec, e_pc;
    logic [7:0]  pp, e_st, e_sp;
    logic [15:0] e_wa [0:2];
    logic [7:0]  e_wd [0:2];
    int unsigned base;

    for (int i = 0; i < 6; i++) mem[32'hFFFA + i] = 8'($urandom);
    pc_in = pc; status_in = st; stack_in = sp;
    is_break = brk; is_rti = rti; nIRQ = nirq; start = 1'b1;
    k = pick();
    push = (k == K_BRK || k == K_NMI || k == K_IRQ);
    halt_len = push ? halt_len_in : 0;
    e_pc = pc; e_st = st; e_sp = sp; lat = 0;
    case (k)
      K_RST: begin
        e_pc = {mem[16'hFFFD], mem[16'hFFFC]};
        e_st = st | 8'h04; e_sp = sp - 8'd3; lat = 3;
      end
      K_RTI: begin
        e_st = mem[{8'h01, 8'(sp + 8'd1)}] & 8'hCF;
        e_pc = {mem[{8'h01, 8'(sp + 8'd3)}], mem[{8'h01, 8'(sp + 8'd2)}]};
        e_sp = sp + 8'd3; lat = 5;
      end
      K_BRK, K_NMI, K_IRQ: begin
        pcp = (k == K_BRK) ? pc + 16'd1 : pc;
        pp  = (k == K_BRK) ? (st | 8'h30) : ((st | 8'h20) & 8'hEF);
        e_wa[0] = {8'h01, sp};          e_wd[0] = pcp[15:8];
        e_wa[1] = {8'h01, 8'(sp - 8'd1)}; e_wd[1] = pcp[7:0];
        e_wa[2] = {8'h01, 8'(sp - 8'd2)}; e_wd[2] = pp;
        vec  = (k == K_NMI) ? 16'hFFFA : 16'hFFFE;
        e_pc = {mem[vec + 16'd1], mem[vec]};
        e_st = (st & 8'hCF) | 8'h04; e_sp = sp - 8'd3; lat = 6;
      end
      default: ;
    endcase
    base = wr_total;

    tick(k == K_NMI, k == K_RST);
    start = 1'b0; is_break = 1'b0; is_rti = 1'b0;

    if (k == K_PASS) begin
      chk({tag, " pass done"}, 32'(done), 32'd1);
      chk({tag, " pass busy"}, 32'(busy), 32'd0);
      chk({tag, " pass pc"}, 32'(pc_out), 32'(e_pc));
      chk({tag, " pass status"}, 32'(status_out), 32'(e_st));
      chk({tag, " pass sp"}, 32'(stack_out), 32'(e_sp));
      chk({tag, " pass writes"}, wr_total, base);
      return;
    end

    chk({tag, " done@S"}, 32'(done), 32'd0);
    chk({tag, " busy@S"}, 32'(busy), 32'd1);
    c = 0; bad_busy = 0; bad_we = 0;
    while (done !== 1'b1 && c < 60) begin
      halt = (halt_len > 0 && c + 1 >= halt_at && c + 1 < halt_at + halt_len);
      if (vbl_pulse && c + 1 == halt_at + 2) ppu_status[7] = 1'b0;
      if (vbl_pulse && c + 1 == halt_at + 4) ppu_status[7] = 1'b1;
      tick(0, 0);
      c++;
      if (halt && bus.mem_write_en !== 1'b0) bad_we = 1;
      if (done !== 1'b1 && busy !== 1'b1) bad_busy = 1;
    end
    halt = 1'b0;
    chk({tag, " latency"}, 32'(c), 32'(lat + halt_len));
    chk({tag, " busy@done"}, 32'(busy), 32'd0);
    chk({tag, " busy held"}, 32'(bad_busy), 32'd0);
    chk({tag, " pc"}, 32'(pc_out), 32'(e_pc));
    chk({tag, " status"}, 32'(status_out), 32'(e_st));
    chk({tag, " sp"}, 32'(stack_out), 32'(e_sp));
    if (halt_len > 0) chk({tag, " we in halt"}, 32'(bad_we), 32'd0);
    if (push) begin
      chk({tag, " nwrites"}, wr_total - base, 32'd3);
      for (int i = 0; i < 3; i++) begin
        chk({tag, " waddr"}, 32'(wl_addr[8'(base + i)]), 32'(e_wa[i]));
        chk({tag, " wdata"}, 32'(wl_data[8'(base + i)]), 32'(e_wd[i]));
      end
    end else begin
      chk({tag, " nwrites"}, wr_total, base);
    end
  endtask

  initial begin
    logic [7:0] sp_r;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1; is_break = 0; soft_reset = 0; is_rti = 0; start = 0; halt = 0;
    nIRQ = 1'b1; ppu_status = 8'h00; ppu_ctrl1 = 8'h00;
    pc_in = 16'h0000; status_in = 8'h00; stack_in = 8'h00;
    repeat (3) tick(0, 0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst addr", 32'(bus.mem_addr), 32'd0);
    chk("rst wdata", 32'(bus.mem_data_out), 32'd0);
    chk("rst we", 32'(bus.mem_write_en), 32'd0);
    chk("rst pc", 32'(pc_out), 32'd0);
    chk("rst status", 32'(status_out), 32'd0);
    chk("rst sp", 32'(stack_out), 32'hFF);
    rst = 1'b0;
    tick(0, 0);

    status_in = 8'h24;
    #1 chk("idisable set", 32'(interrupt_disable), 32'd1);
    status_in = 8'h20;
    #1 chk("idisable clr", 32'(interrupt_disable), 32'd0);

    run("passthru", 16'h8123, 8'h24, 8'hFD, 0, 0, 1, 0, 0, 0);

    ppu_ctrl1 = 8'h80; ppu_status = 8'h80;
    tick(0, 0);
    run("nmi", 16'hC000, 8'h01, 8'hFD, 0, 0, 1, 0, 0, 0);
    run("nmi once", 16'hC010, 8'h01, 8'hFD, 0, 0, 1, 0, 0, 0);

    run("brk", 16'h8001, 8'h81, 8'hFD, 1, 0, 1, 0, 0, 0);
    run("irq masked", 16'h9000, 8'h04, 8'hF0, 0, 0, 0, 0, 0, 0);
    run("irq", 16'h9000, 8'h00, 8'hF0, 0, 0, 0, 0, 0, 0);

    mem[16'h01FB] = 8'hF3; mem[16'h01FC] = 8'h34; mem[16'h01FD] = 8'h12;
    run("rti", 16'h4000, 8'h00, 8'hFA, 0, 1, 1, 0, 0, 0);
    chk("rti pc const", 32'(pc_out), 32'h1234);
    chk("rti st const", 32'(status_out), 32'hC3);

    mem[16'h01FF] = 8'h0F; mem[16'h0100] = 8'h78; mem[16'h0101] = 8'h56;
    run("rti wrap", 16'h4000, 8'h00, 8'hFE, 0, 1, 1, 0, 0, 0);
    chk("rti wrap sp", 32'(stack_out), 32'h01);

    soft_reset = 1'b1; tick(0, 0); soft_reset = 1'b0;
    run("softrst", 16'h1234, 8'h80, 8'hFD, 0, 1, 0, 0, 0, 0);

    ppu_status[7] = 1'b0; tick(0, 0);
    ppu_status[7] = 1'b1; tick(0, 0);
    run("nmi halt", 16'hC000, 8'h01, 8'hFD, 0, 0, 1, 1, 10, 1);
    run("nmi relatch", 16'hC100, 8'h00, 8'hFA, 0, 0, 1, 0, 0, 0);

    // Abort mid-sequence
    pc_in = 16'h8000; status_in = 8'h00; stack_in = 8'hFD; is_break = 1'b1; start = 1'b1;
    tick(0, 0);
    start = 1'b0; is_break = 1'b0;
    tick(0, 0); tick(0, 0);
    rst = 1'b1; tick(0, 0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort we", 32'(bus.mem_write_en), 32'd0);
    chk("abort sp", 32'(stack_out), 32'hFF);
    chk("abort pc", 32'(pc_out), 32'd0);
    rst = 1'b0; tick(0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        soft_reset = 1'b1; tick(0, 0); soft_reset = 1'b0;
      end
      ppu_ctrl1 = 8'($urandom);
      ppu_status = {ppu_status[7], 7'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        ppu_status[7] = 1'b0; tick(0, 0);
        ppu_status[7] = 1'b1; tick(0, 0);
      end
      sp_r = 8'($urandom);
      for (int i = 1; i <= 3; i++) mem[{8'h01, 8'(sp_r + 8'(i))}] = 8'($urandom);
      run("rand", 16'($urandom), 8'($urandom), sp_r,
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 1)), $urandom_range(1, 3),
          $urandom_range(0, 1) * $urandom_range(1, 4), 0);
      repeat ($urandom_range(0, 2)) tick(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
